// File: rtl/fpcvt_pkg.sv
// ============================================================================
// Module : fpcvt_pkg
// Brief  : Shared widths, FSM encoding and helpers for the fpcvt scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fpcvt_pkg;

  localparam int D_W   = 13;
  localparam int E_W   = 3;
  localparam int F_W   = 5;
  localparam int CNT_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CONV = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  // A result is saturated when both exponent and significand are all ones.
  function automatic logic is_sat(input logic [E_W-1:0] e, input logic [F_W-1:0] f);
    return (e == {E_W{1'b1}}) && (f == {F_W{1'b1}});
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpcvt.sv
// ============================================================================
// Module : fpcvt
// Brief  : Combinational 13-bit two's-complement to S/E[2:0]/F[4:0] converter
//          with round-half-up on the first dropped bit and saturation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fpcvt (
  input  logic [12:0] D,
  output logic        S,
  output logic [2:0]  E,
  output logic [4:0]  F
);

  logic [12:0] mag;
  logic [3:0]  e_raw;
  logic [4:0]  f_trunc;
  logic        rnd;
  logic [5:0]  sum;

  always_comb begin
    S     = D[12];
    mag   = D[12] ? (~D + 13'd1) : D;
    e_raw = 4'd0;
    for (int p = 5; p < 12; p++) begin
      if (mag[p]) e_raw = 4'(p - 4);
    end
    f_trunc = 5'(mag >> e_raw);
    rnd     = (e_raw == 4'd0) ? 1'b0 : mag[e_raw - 4'd1];
    sum     = {1'b0, f_trunc} + {5'd0, rnd};
    E       = e_raw[2:0];
    F       = sum[4:0];
    // Rounding overflow renormalises to 10000 one exponent higher, or saturates.
    if (mag[12]) begin
      E = 3'd7;
      F = 5'h1F;
    end else if (sum[5]) begin
      if (e_raw == 4'd7) begin
        E = 3'd7;
        F = 5'h1F;
      end else begin
        E = e_raw[2:0] + 3'd1;
        F = 5'b10000;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpcvt_rr_arb.sv
// ============================================================================
// Module : fpcvt_rr_arb
// Brief  : Combinational round-robin picker: first request at or above ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fpcvt_rr_arb #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            any_o
);

  int idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = ID_W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpcvt_sched.sv
// ============================================================================
// Module : fpcvt_sched
// Brief  : Round-robin scheduler sharing one fpcvt among NREQ requesters.
//          Optional statistics counters: define FPCVT_SCHED_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fpcvt_sched
  import fpcvt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*D_W-1:0] req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ID_W-1:0]     out_id,
  output logic                out_s,
  output logic [E_W-1:0]      out_e,
  output logic [F_W-1:0]      out_f,
  output logic                busy,
  output logic [CNT_W-1:0]    cnt_conv,
  output logic [CNT_W-1:0]    cnt_sat
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [D_W-1:0]    d_q;
  logic [ID_W-1:0]   id_q;
  logic              out_valid_q;
  logic [ID_W-1:0]   out_id_q;
  logic              out_s_q;
  logic [E_W-1:0]    out_e_q;
  logic [F_W-1:0]    out_f_q;

  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any;
  logic [D_W-1:0]    sel_data;
  logic              cv_s;
  logic [E_W-1:0]    cv_e;
  logic [F_W-1:0]    cv_f;
  logic              accept;
  logic              load_out;
  logic              out_hs;

  fpcvt_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (gnt_any)
  );

  fpcvt u_fpcvt (
    .D (d_q),
    .S (cv_s),
    .E (cv_e),
    .F (cv_f)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_data = req_data[i*D_W +: D_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_any) state_d = ST_CONV;
      ST_CONV: state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Grants are masked by rst_n so nothing is offered while reset is asserted.
  always_comb begin
    req_ready = (rst_n && (state_q == ST_IDLE)) ? gnt : '0;
    busy      = (state_q != ST_IDLE);
    accept    = (state_q == ST_IDLE) && gnt_any;
    load_out  = (state_q == ST_CONV);
    out_hs    = (state_q == ST_HOLD) && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      d_q         <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_s_q     <= 1'b0;
      out_e_q     <= '0;
      out_f_q     <= '0;
    end else begin
      if (accept) begin
        d_q  <= sel_data;
        id_q <= gnt_id;
      end
      if (load_out) begin
        out_valid_q <= 1'b1;
        out_id_q    <= id_q;
        out_s_q     <= cv_s;
        out_e_q     <= cv_e;
        out_f_q     <= cv_f;
      end
      if (out_hs) begin
        out_valid_q <= 1'b0;
        rr_ptr_q    <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_s     = out_s_q;
  assign out_e     = out_e_q;
  assign out_f     = out_f_q;

`ifdef FPCVT_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_conv_q;
  logic [CNT_W-1:0] cnt_sat_q;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_conv_q <= '0;
      cnt_sat_q  <= '0;
    end else if (out_hs) begin
      if (cnt_conv_q != {CNT_W{1'b1}}) cnt_conv_q <= cnt_conv_q + 1'b1;
      if (is_sat(out_e_q, out_f_q) && (cnt_sat_q != {CNT_W{1'b1}}))
        cnt_sat_q <= cnt_sat_q + 1'b1;
    end
  end

  assign cnt_conv = cnt_conv_q;
  assign cnt_sat  = cnt_sat_q;
`else
  assign cnt_conv = '0;
  assign cnt_sat  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpcvt_sched.sv
// ============================================================================
// Module : tb_fpcvt_sched
// Brief  : Scoreboard bench for fpcvt_sched (honours FPCVT_SCHED_STATS_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fpcvt_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [51:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic        out_s;
  logic [2:0]  out_e;
  logic [4:0]  out_f;
  logic        busy;
  logic [15:0] cnt_conv;
  logic [15:0] cnt_sat;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [10:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpcvt_sched #(.NREQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f),
    .busy      (busy),
    .cnt_conv  (cnt_conv),
    .cnt_sat   (cnt_sat)
  );

  // Smallest exponent whose rounded significand fits in 5 bits, else saturate.
  function automatic logic [8:0] model(input logic [12:0] d);
    logic s;
    int   m;
    int   f;
    s = d[12];
    m = s ? (8192 - int'(d)) : int'(d);
    for (int e = 0; e < 8; e++) begin
      f = (e == 0) ? m : ((m + (1 << (e - 1))) >> e);
      if (f < 32) return {s, 3'(e), 5'(f)};
    end
    return {s, 3'd7, 5'd31};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL result_unexpected: got id=%0d s=%0d e=%0d f=%0d, none expected",
                 out_id, out_s, out_e, out_f);
      end else begin
        logic [10:0] exp_r;
        exp_r = sb.pop_front();
        if ({out_id, out_s, out_e, out_f} !== exp_r) begin
          bad++;
          $display("FAIL result: got id=%0d s=%0d e=%b f=%b, want id=%0d s=%0d e=%b f=%b",
                   out_id, out_s, out_e, out_f, exp_r[10:9], exp_r[8], exp_r[7:5], exp_r[4:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [12:0] v);
    req_data[13*i +: 13] = v;
  endtask

  task automatic push_exp(input int id, input logic [12:0] v);
    sb.push_back({2'(id), model(v)});
  endtask

  task automatic apply_reset();
    req_valid = 4'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Run until one output handshake, retiring accepted requests on the way.
  task automatic drain_one();
    logic [3:0] acc;
    bit         seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (out_valid && out_ready) seen = 1'b1;
      tick();
      req_valid = req_valid & ~acc;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL drain_timeout: got no handshake in 20 cycles, want one");
    end
  endtask

  task automatic convert_one(input int id, input logic [12:0] v);
    set_data(id, v);
    push_exp(id, v);
    req_valid = 4'(1 << id);
    drain_one();
    req_valid = 4'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    req_valid = 4'hF;
    req_data  = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0) begin
      bad++;
      $display("FAIL reset_ready_low: got %b want 0000", req_ready);
    end
    tick();
    req_valid = 4'b0;
    rst_n     = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    @(negedge clk);
    total++;
    if ({out_valid, req_ready, busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b busy=%b want 0/0000/0",
               out_valid, req_ready, busy);
    end
    total++;
    if ({out_id, out_s, out_e, out_f} !== 11'b0) begin
      bad++;
      $display("FAIL reset_out: got id=%0d s=%0d e=%0d f=%0d want all 0",
               out_id, out_s, out_e, out_f);
    end
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    set_data(0, 13'd253);
    push_exp(0, 13'd253);
    req_valid = 4'b0001;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_grant: got %b want 0001", req_ready);
    end
    tick();
    req_valid = 4'b0;
    @(negedge clk);
    total++;
    if ({req_ready, out_valid, busy} !== 6'b0000_0_1) begin
      bad++;
      $display("FAIL single_conv: got ready=%b valid=%b busy=%b want 0000/0/1",
               req_ready, out_valid, busy);
    end
    tick();
    @(negedge clk);
    total++;
    if ({out_valid, out_id, out_s, out_e, out_f} !== {1'b1, 2'd0, 1'b0, 3'b100, 5'b10000}) begin
      bad++;
      $display("FAIL single_result: got v=%b id=%0d s=%b e=%b f=%b want 1/0/0/100/10000",
               out_valid, out_id, out_s, out_e, out_f);
    end
    tick();
    @(negedge clk);
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL single_idle: got valid=%b busy=%b want 0/0", out_valid, busy);
    end
    tick();
  endtask

  task automatic test_all_valid();
    logic [8:0] exp_tab [4];
    logic [3:0] acc;
    int         n;
    int         last;
    exp_tab[0] = 9'b0_000_00001;
    exp_tab[1] = 9'b1_000_00001;
    exp_tab[2] = 9'b0_000_01000;
    exp_tab[3] = 9'b0_111_11111;
    apply_reset();
    out_ready = 1'b1;
    set_data(0, 13'd1);
    set_data(1, 13'h1FFF);
    set_data(2, 13'd8);
    set_data(3, 13'd4095);
    for (int i = 0; i < 4; i++) push_exp(i, req_data[13*i +: 13]);
    req_valid = 4'hF;
    n    = 0;
    last = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (out_valid) begin
        total++;
        if ({out_id, out_s, out_e, out_f} !== {2'(n), exp_tab[n]}) begin
          bad++;
          $display("FAIL rr_order_%0d: got id=%0d code=%b want id=%0d code=%b",
                   n, out_id, {out_s, out_e, out_f}, n, exp_tab[n]);
        end
        if (n > 0) begin
          total++;
          if (cyc - last != 3) begin
            bad++;
            $display("FAIL rr_spacing_%0d: got %0d cycles want 3", n, cyc - last);
          end
        end
        last = cyc;
        n++;
      end
      tick();
      req_valid = req_valid & ~acc;
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL rr_count: got %0d results want 4", n);
    end
    req_valid = 4'b0;
  endtask

  task automatic test_hold();
    logic [8:0] exp0;
    out_ready = 1'b0;
    set_data(0, 13'd100);
    set_data(1, 13'd200);
    set_data(2, 13'd300);
    set_data(3, 13'd400);
    exp0 = model(13'd100);
    push_exp(0, 13'd100);
    req_valid = 4'hF;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL ptr_after_wrap: got grant %b want 0001", req_ready);
    end
    tick();
    req_valid = 4'b1110;
    tick();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if ({out_valid, req_ready, busy, out_id, out_s, out_e, out_f} !==
          {1'b1, 4'b0, 1'b1, 2'd0, exp0}) begin
        bad++;
        $display("FAIL hold_%0d: got v=%b rdy=%b busy=%b id=%0d code=%b want 1/0000/1/0/%b",
                 c, out_valid, req_ready, busy, out_id, {out_s, out_e, out_f}, exp0);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL hold_next_grant: got %b want 0010", req_ready);
    end
    push_exp(1, 13'd200);
    drain_one();
    req_valid = 4'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL mid_grant: got %b want 0100", req_ready);
    end
    tick();
    req_valid = 4'b1011;
    rst_n     = 1'b0;
    @(negedge clk);
    total++;
    if ({req_ready, out_valid} !== 5'b0) begin
      bad++;
      $display("FAIL mid_in_reset: got ready=%b valid=%b want 0000/0", req_ready, out_valid);
    end
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({out_valid, busy} !== 2'b00) begin
        bad++;
        $display("FAIL mid_aborted_%0d: got valid=%b busy=%b want 0/0", c, out_valid, busy);
      end
      tick();
    end
    req_valid = 4'hF;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL mid_ptr_reset: got grant %b want 0001", req_ready);
    end
    push_exp(0, req_data[12:0]);
    drain_one();
    req_valid = 4'b0;
  endtask

  task automatic test_stats();
    logic [15:0] exp_conv;
    logic [15:0] exp_sat;
`ifdef FPCVT_SCHED_STATS_EN
    exp_conv = 16'd3;
    exp_sat  = 16'd2;
`else
    exp_conv = 16'd0;
    exp_sat  = 16'd0;
`endif
    apply_reset();
    @(negedge clk);
    total++;
    if ({cnt_conv, cnt_sat} !== 32'b0) begin
      bad++;
      $display("FAIL stats_reset: got conv=%0d sat=%0d want 0/0", cnt_conv, cnt_sat);
    end
    tick();
    out_ready = 1'b1;
    convert_one(0, 13'd4095);
    convert_one(1, 13'h1000);
    convert_one(2, 13'd506);
    @(negedge clk);
    total++;
    if ({cnt_conv, cnt_sat} !== {exp_conv, exp_sat}) begin
      bad++;
      $display("FAIL stats_counts: got conv=%0d sat=%0d want %0d/%0d",
               cnt_conv, cnt_sat, exp_conv, exp_sat);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_hold();
    test_reset_mid();
    test_stats();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending results want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
